i2c_master_ctrl: RTL and testbench

- Single-master I2C transaction sequencer that drives the open-drain SCL/SDA pair the i2c slave block listens on.
- Accepts one command per transaction: START, 7-bit address + R/W, address ACK, one data byte (write or read), ACK/NACK, STOP.
- Sits between a CPU/register-file requester (valid/ready) and the board's `ck_scl`/`ck_sda` pads (`*_oe` drives low, released = pulled high).
- Also serves as the bus stimulus engine for slave verification.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_quarter_timer.sv | 39 +++
 rtl/i2c_master_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master sequencer.
// Imported by the quarter timer and the controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } i2c_mst_state_t;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_ACK      = 1'b0;

    localparam int QUARTERS_PER_BIT = 4;

    // START only spans two quarters, so idle parks the
    // quarter index here and START wraps into bit Q0.
    localparam logic [1:0] START_QUARTER = 2'd2;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-SCL-period divider with a stall input for clock stretching.
// Emits one tick per quarter and tracks the quarter index.
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       run,
    input  logic       stall,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run & ~stall & (cnt == LAST);

    // Count cycles per quarter; freeze while stalled, park when idle
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            quarter <= START_QUARTER;
        end else if (!run) begin
            cnt     <= '0;
            quarter <= START_QUARTER;
        end else if (tick) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else if (!stall) begin
            cnt     <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, data, ACK, STOP.
// Drives open-drain SCL/SDA enables; honours slave clock stretching.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam logic [1:0] Q_LAST   = 2'(QUARTERS_PER_BIT - 1);
    localparam logic [1:0] Q_SAMPLE = 2'd2;

    i2c_mst_state_t state, state_nxt;

    logic [1:0] quarter;
    logic       tick;
    logic       stretch;
    logic       run;
    logic       accept;
    logic       bit_end;
    logic       sample;
    logic       last_bit;
    logic       is_read;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] wdata_q;
    logic       rw_q;

    assign run       = (state != IDLE);
    assign busy      = run;
    assign cmd_ready = (state == IDLE) & ~done;
    assign accept    = cmd_valid & cmd_ready;
    assign bit_end   = tick & (quarter == Q_LAST);
    assign sample    = tick & (quarter == Q_SAMPLE);
    assign last_bit  = (bit_cnt == 3'd7);
    assign is_read   = (rw_q == I2C_RW_READ);

    // Phases where SCL is released and time waits for it to read high
    always_comb begin
        stretch = 1'b0;
        unique case (state)
            ADDR, ADDR_ACK, DATA, DATA_ACK:
                stretch = (quarter == 2'd2);
            STOP:
                stretch = (quarter == 2'd1);
            default:
                stretch = 1'b0;
        endcase
    end

    i2c_quarter_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk100 (clk100),
        .reset  (reset),
        .run    (run),
        .stall  (stretch & ~scl_in),
        .tick   (tick),
        .quarter(quarter)
    );

    // State register
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and open-drain enables
    always_comb begin
        state_nxt = state;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                sda_oe = 1'b1;
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_oe = ~quarter[1];
                sda_oe = ~shreg[7];
                if (bit_end && last_bit) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_oe = ~quarter[1];
                if (bit_end) state_nxt = nack ? STOP : DATA;
            end
            DATA: begin
                scl_oe = ~quarter[1];
                sda_oe = (rw_q == I2C_RW_WRITE) & ~shreg[7];
                if (bit_end && last_bit) state_nxt = DATA_ACK;
            end
            DATA_ACK: begin
                scl_oe = ~quarter[1];
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                scl_oe = (quarter == 2'd0);
                sda_oe = ~quarter[1];
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command shadow, shifter, bit count, ack and result flags
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            bit_cnt <= '0;
            rdata   <= '0;
            nack    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= {cmd_addr, cmd_rw};
                        rw_q    <= cmd_rw;
                        wdata_q <= cmd_wdata;
                        bit_cnt <= '0;
                        nack    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (bit_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ADDR_ACK: begin
                    if (sample && sda_in != I2C_ACK) nack <= 1'b1;
                    if (bit_end) shreg <= wdata_q;
                end
                DATA: begin
                    if (sample && is_read) begin
                        shreg <= {shreg[6:0], sda_in};
                        if (last_bit) rdata <= {shreg[6:0], sda_in};
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (!is_read) shreg <= {shreg[6:0], 1'b0};
                    end
                end
                DATA_ACK: begin
                    if (sample && !is_read && sda_in != I2C_ACK)
                        nack <= 1'b1;
                end
                STOP: begin
                    if (bit_end) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: pulled-up bus, byte-level slave
// model at address 0x42, latency and bus-content checks.
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 25;
    localparam logic [6:0] SLV = 7'h42;

    logic       clk100    = 1'b0;
    logic       reset     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [6:0] cmd_addr  = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, done, nack, busy, scl_oe, sda_oe;
    logic [7:0] rdata;

    logic hold   = 1'b0;
    logic sl_sda = 1'b0;
    logic scl_w, sda_w;

    assign scl_w = ~scl_oe & ~hold;
    assign sda_w = ~sda_oe & ~sl_sda;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;
    int rcnt = 0;

    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       acked = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
    logic [7:0] ab = '0, db = '0, rd_byte = '0;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk100   (clk100),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_rw   (cmd_rw),
        .cmd_wdata(cmd_wdata),
        .rdata    (rdata),
        .done     (done),
        .nack     (nack),
        .busy     (busy),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .scl_in   (scl_w),
        .sda_in   (sda_w)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    // Slave model: captures bytes on SCL rise, drives ACK/read data on fall
    always @(negedge clk100) begin
        scl_p <= scl_w;
        sda_p <= sda_w;
        if (scl_w && scl_p && sda_p && !sda_w) begin
            rcnt   <= 0;
            sl_sda <= 1'b0;
            acked  <= 1'b0;
        end else if (scl_w && !scl_p) begin
            if (rcnt < 8)        ab   <= {ab[6:0], sda_w};
            else if (rcnt == 8)  ack1 <= sda_w;
            else if (rcnt < 17)  db   <= {db[6:0], sda_w};
            else if (rcnt == 17) ack2 <= sda_w;
            rcnt <= rcnt + 1;
        end else if (!scl_w && scl_p) begin
            if (rcnt == 8) begin
                acked  <= (ab[7:1] == SLV);
                sl_sda <= (ab[7:1] == SLV);
            end else if (rcnt >= 9 && rcnt <= 16) begin
                sl_sda <= acked & ab[0] & ~rd_byte[16-rcnt];
            end else if (rcnt == 17) begin
                sl_sda <= acked & ~ab[0];
            end else begin
                sl_sda <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] a, input logic rw,
                         input logic [7:0] wd, output int t);
        int n;
        n = 0;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk100);
            n++;
        end
        chk("accept_seen", cmd_ready, 1'b1);
        t = cyc;
        @(negedge clk100);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        t = -1;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk100);
            n++;
        end
        if (done === 1'b1) t = cyc;
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        int t_acc, t_done, n;

        // Reset values
        repeat (3) @(negedge clk100);
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_nack", nack, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ready", cmd_ready, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk100);

        // Write 0x42 <- 0xA5
        issue(7'h42, 1'b0, 8'hA5, t_acc);
        chk("wr_busy", busy, 1'b1);
        chk("wr_ready_busy", cmd_ready, 1'b0);
        wait_done(t_done);
        chk("wr_lat", t_done - t_acc, 1951);
        chk("wr_nack", nack, 1'b0);
        chk("wr_addr_byte", ab, 8'h84);
        chk("wr_addr_ack", ack1, 1'b0);
        chk("wr_data_byte", db, 8'hA5);
        chk("wr_data_ack", ack2, 1'b0);
        chk("wr_busy_done", busy, 1'b0);
        @(negedge clk100);
        chk("wr_done_pulse", done, 1'b0);
        chk("wr_nack_held", nack, 1'b0);

        // Address NACK: 0x17 is not present
        issue(7'h17, 1'b0, 8'hFF, t_acc);
        wait_done(t_done);
        chk("nk_lat", t_done - t_acc, 1051);
        chk("nk_nack", nack, 1'b1);
        chk("nk_addr_byte", ab, 8'h2E);
        chk("nk_addr_ack", ack1, 1'b1);
        chk("nk_scl_rises", rcnt, 10);
        @(negedge clk100);
        chk("nk_nack_held", nack, 1'b1);

        // Read 0x42 -> 0x3C
        rd_byte = 8'h3C;
        issue(7'h42, 1'b1, 8'h00, t_acc);
        chk("rd_nack_clr", nack, 1'b0);
        wait_done(t_done);
        chk("rd_lat", t_done - t_acc, 1951);
        chk("rd_rdata", rdata, 8'h3C);
        chk("rd_nack", nack, 1'b0);
        chk("rd_addr_byte", ab, 8'h85);
        chk("rd_master_nack", ack2, 1'b1);

        // Write with a 300-cycle stretch in the 5th address bit
        issue(7'h42, 1'b0, 8'h96, t_acc);
        n = 0;
        while (!(rcnt == 4 && !scl_w) && n < 3000) begin
            @(negedge clk100);
            n++;
        end
        chk("st_sync", (n < 3000), 1'b1);
        hold = 1'b1;
        n = 0;
        while (scl_oe !== 1'b0 && n < 3000) begin
            @(negedge clk100);
            n++;
        end
        repeat (300) @(negedge clk100);
        hold = 1'b0;
        wait_done(t_done);
        chk("st_lat", t_done - t_acc, 2251);
        chk("st_addr_byte", ab, 8'h84);
        chk("st_data_byte", db, 8'h96);
        chk("st_nack", nack, 1'b0);

        // Reset during the 3rd data bit
        issue(7'h42, 1'b0, 8'hC3, t_acc);
        n = 0;
        while (!(rcnt == 11 && !scl_w) && n < 3000) begin
            @(negedge clk100);
            n++;
        end
        chk("mr_pre_scl_oe", scl_oe, 1'b1);
        reset = 1'b0;
        #1;
        chk("mr_scl_oe", scl_oe, 1'b0);
        chk("mr_sda_oe", sda_oe, 1'b0);
        @(negedge clk100);
        reset = 1'b1;
        @(negedge clk100);
        chk("mr_ready", cmd_ready, 1'b1);
        chk("mr_busy", busy, 1'b0);
        issue(7'h42, 1'b0, 8'h5A, t_acc);
        wait_done(t_done);
        chk("mr_lat", t_done - t_acc, 1951);
        chk("mr_data_byte", db, 8'h5A);
        chk("mr_nack", nack, 1'b0);

        // cmd_valid held high across two commands
        rd_byte   = 8'hC3;
        cmd_addr  = 7'h42;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h11;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk100);
            n++;
        end
        t_acc = cyc;
        @(negedge clk100);
        cmd_rw    = 1'b1;
        cmd_wdata = 8'hEE;
        wait_done(t_done);
        chk("bb_lat1", t_done - t_acc, 1951);
        chk("bb_ready_done", cmd_ready, 1'b0);
        chk("bb_addr1", ab, 8'h84);
        chk("bb_data1", db, 8'h11);
        @(negedge clk100);
        chk("bb_ready_after", cmd_ready, 1'b1);
        t_acc = cyc;
        chk("bb_gap", t_acc - t_done, 1);
        @(negedge clk100);
        cmd_valid = 1'b0;
        chk("bb_busy2", busy, 1'b1);
        wait_done(t_done);
        chk("bb_lat2", t_done - t_acc, 1951);
        chk("bb_addr2", ab, 8'h85);
        chk("bb_rdata2", rdata, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
